// File: rtl/telemetry_tx.sv
// telemetry_tx: serialises component telemetry records into ASCII lines of the
// form "<k> <id> <idx> <hex>\n" for the client link.
//
// Records enter through a small FIFO (rec_*). The head record is copied into a
// message register, and its bytes stream out over a valid/ready byte port (tx_*).
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   en_i         allow new messages to start (sampled only at message start)
//   rec_valid_i  record offered          rec_ready_o  FIFO not full
//   rec_kind_i   0 = 'b', 1 = 'f'        rec_id_i     component id
//   rec_index_i  variable index          rec_value_i  value, printed as hex
//   tx_data_o    ASCII byte              tx_valid_o   byte valid
//   tx_ready_i   byte consumed           busy_o       message in flight
//   level_o      FIFO occupancy; the message register is not counted
module telemetry_tx #(
  parameter int VW    = 16,
  parameter int NHEX  = VW / 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          rec_valid_i,
  output logic          rec_ready_o,
  input  logic          rec_kind_i,
  input  logic [1:0]    rec_id_i,
  input  logic [2:0]    rec_index_i,
  input  logic [VW-1:0] rec_value_i,
  output logic [7:0]    tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  output logic          busy_o,
  output logic [AW:0]   level_o
);

  localparam int L  = 8 + NHEX;
  localparam int CW = $clog2(L);

  typedef struct packed {
    logic          kind;
    logic [1:0]    id;
    logic [2:0]    idx;
    logic [VW-1:0] value;
  } rec_t;

  typedef enum logic {IDLE, SEND} state_t;

  rec_t          mem_q [DEPTH];
  rec_t          rec_in;
  rec_t          msg_q, msg_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic          push, pop, have, hs, last;

  assign rec_in      = '{kind: rec_kind_i, id: rec_id_i, idx: rec_index_i, value: rec_value_i};
  assign rec_ready_o = (level_q != (AW+1)'(DEPTH));
  assign push        = rec_valid_i && rec_ready_o;
  assign have        = (level_q != '0);
  assign hs          = (state_q == SEND) && tx_ready_i;
  assign last        = (cnt_q == CW'(L-1));
  assign busy_o      = (state_q == SEND);
  assign tx_valid_o  = (state_q == SEND);
  assign level_o     = level_q;

  // ---------------- FIFO ----------------
  // Storage needs no reset: level_q alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= rec_in;
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // ---------------- FSM ----------------
  // A pop happens either from IDLE or on the final byte handshake, so the next
  // message follows the '\n' with no bubble cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && have) begin
          pop     = 1'b1;
          msg_d   = mem_q[rptr_q];
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (!last) begin
            cnt_d = cnt_q + CW'(1);
          end else if (en_i && have) begin
            pop   = 1'b1;
            msg_d = mem_q[rptr_q];
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      msg_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
      wptr_q  <= wptr_q + AW'(push);
      rptr_q  <= rptr_q + AW'(pop);
      level_q <= level_d;
    end
  end

  // ---------------- byte formatter ----------------
  // Decoded purely from registered state, so tx_data_o is stable while stalled
  // and drops to 00 as soon as reset forces IDLE.
  logic [CW-1:0] di;
  logic [3:0]    nib;

  always_comb begin
    di        = cnt_q - CW'(7);
    nib       = 4'(msg_q.value >> (4 * (NHEX - 1 - int'(di))));
    tx_data_o = 8'h00;
    if (state_q == SEND) begin
      case (cnt_q)
        CW'(0):                 tx_data_o = msg_q.kind ? 8'h66 : 8'h62;
        CW'(1), CW'(4), CW'(6): tx_data_o = 8'h20;
        CW'(2):                 tx_data_o = 8'h30 + {7'd0, msg_q.id[1]};
        CW'(3):                 tx_data_o = 8'h30 + {7'd0, msg_q.id[0]};
        CW'(5):                 tx_data_o = 8'h30 + {5'd0, msg_q.idx};
        default: begin
          if (last)              tx_data_o = 8'h0A;
          else if (nib < 4'd10)  tx_data_o = 8'h30 + {4'd0, nib};
          else                   tx_data_o = 8'h37 + {4'd0, nib};  // 'A' - 10
        end
      endcase
    end
  end

endmodule
